reg_intf_master: RTL and testbench
==================================

REG_INTF_MASTER -- requirements
Module: reg_intf_master

Interface
REQ-001 SHALL have parameter POLL_GAP, default 4, meaning the number of idle cycles between consecutive poll reads (valid range 1..65535).
REQ-002 SHALL have parameter POLL_MAX, default 256, meaning the maximum number of reads per poll command (valid range 1..65535).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-006 SHALL have port cmd_ready, output, 1 bit: the block accepts a command.
REQ-007 SHALL have port cmd_op, input, 2 bits: 00 write, 01 read, 10 poll, 11 reserved.
REQ-008 SHALL have port cmd_addr, input, 14 bits: register address.
REQ-009 SHALL have port cmd_wdata, input, 16 bits: write data for a write command, or bit mask for a poll command.
REQ-010 SHALL have port wr_en, output, 1 bit: register-file write strobe.
REQ-011 SHALL have port rd_en, output, 1 bit: register-file read strobe (read-to-clear trigger).
REQ-012 SHALL have port addr, output, 14 bits: register-file address.
REQ-013 SHALL have port write_data, output, 16 bits: register-file write data.
REQ-014 SHALL have port read_data, input, 16 bits: register-file read data, combinational from addr.
REQ-015 SHALL have port rsp_valid, output, 1 bit: a response is available.
REQ-016 SHALL have port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-017 SHALL have port rsp_data, output, 16 bits: captured read data.
REQ-018 SHALL have port rsp_err, output, 1 bit: poll timeout or reserved op.

Function
REQ-019 SHALL implement the FSM states IDLE, ISSUE, POLL_WAIT and RESP.
REQ-020 In IDLE, cmd_ready SHALL be 1; in every other state it SHALL be 0.
REQ-021 When cmd_valid and cmd_ready are both 1 at a clock edge, the block SHALL latch op, addr and wdata, load addr and write_data, and enter ISSUE, or enter RESP with rsp_err=1 and rsp_data=0 for op 11.
REQ-022 wr_en, rd_en, addr and write_data SHALL be registered outputs.
REQ-023 In ISSUE, exactly one strobe SHALL be high for exactly one cycle: wr_en for a write, rd_en for a read or poll.
REQ-024 wr_en and rd_en SHALL never be high in the same cycle.
REQ-025 write_data SHALL be 0 during read and poll accesses.
REQ-026 read_data SHALL be captured into rsp_data at the clock edge that ends the rd_en cycle.
REQ-027 On that capture edge, a write or read SHALL enter RESP; a write response SHALL have rsp_data=0.
REQ-028 On that capture edge, a poll whose (read_data & mask) != 0 SHALL enter RESP with rsp_err=0.
REQ-029 On that capture edge, a poll whose read count equals POLL_MAX SHALL enter RESP with rsp_err=1 and rsp_data equal to the last read.
REQ-030 On that capture edge, any other poll SHALL enter POLL_WAIT.
REQ-031 POLL_WAIT SHALL last exactly POLL_GAP cycles and then return to ISSUE, so successive rd_en pulses are POLL_GAP+1 cycles apart.
REQ-032 The poll read counter SHALL be 16 bits, cleared on command accept, and incremented on each rd_en.
REQ-033 A mask of 0 SHALL always time out after POLL_MAX reads.
REQ-034 In RESP, rsp_valid SHALL be 1, and rsp_data and rsp_err SHALL be held stable until rsp_ready is 1.
REQ-035 The block SHALL return to IDLE on the edge where rsp_valid and rsp_ready are both 1.
REQ-036 Latency SHALL be: command accepted at edge N, strobe high in cycle N+1, rsp_valid high from cycle N+2 (write/read); peak throughput is one command per 3 cycles.
REQ-037 addr SHALL hold its last value when the block is not issuing.
REQ-038 The block SHALL perform no bus access outside ISSUE.

Reset
REQ-039 While rst=0, the state SHALL be IDLE, and wr_en, rd_en, addr, write_data, rsp_valid, rsp_data, rsp_err and the poll counter SHALL be 0, with cmd_ready=1, applied asynchronously.
REQ-040 Reset asserted mid-command SHALL drop that command with no further strobe.
REQ-041 The first command SHALL be accepted no earlier than the first rising edge after rst deasserts.

Verification
REQ-042 Write addr 0x0002 data 0xBEEF -> one wr_en cycle with addr=0x0002 and write_data=0xBEEF, then rsp_valid the next cycle with rsp_data=0 and rsp_err=0.
REQ-043 Read addr 0x0014 with the model returning 0x0003 -> one rd_en cycle, then rsp_data=0x0003 and rsp_err=0.
REQ-044 Poll addr 0x0014 mask 0x0001, with bit0 set from the 3rd read on -> exactly 3 rd_en pulses 5 cycles apart, then rsp_err=0 and rsp_data bit0=1.
REQ-045 Poll with POLL_MAX=4 and the condition never met -> 4 rd_en pulses, then rsp_err=1 with rsp_data equal to the last read.
REQ-046 Hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data and rsp_err stable, cmd_ready=0, no strobes; cmd_ready=1 the cycle after the handshake.
REQ-047 Assert rst during POLL_WAIT -> all outputs 0 immediately, no rd_en after release, next command behaves as a fresh command.

Source files
------------

// File: rtl/reg_intf_master.sv
`default_nettype none
// ============================================================================
// Module   : reg_intf_master
// Purpose  : Command-driven register-file master: write, read and masked poll.
// Revision : 1.0
// ============================================================================
module reg_intf_master #(
    parameter int POLL_GAP = 4,
    parameter int POLL_MAX = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [13:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        wr_en,
    output logic        rd_en,
    output logic [13:0] addr,
    output logic [15:0] write_data,
    input  logic [15:0] read_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err
);

    localparam logic [1:0]  c_OP_WRITE = 2'b00;
    localparam logic [1:0]  c_OP_READ  = 2'b01;
    localparam logic [1:0]  c_OP_RSVD  = 2'b11;
    localparam logic [15:0] c_POLL_MAX = 16'(POLL_MAX);
    localparam logic [15:0] c_GAP_LAST = 16'(POLL_GAP - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        POLL_WAIT = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_op;
    logic [1:0]  w_op_next;
    logic [15:0] r_mask;
    logic [15:0] w_mask_next;
    logic [15:0] r_poll_cnt;
    logic [15:0] w_poll_cnt_next;
    logic [15:0] w_poll_cnt_inc;
    logic [15:0] r_gap_cnt;
    logic [15:0] w_gap_cnt_next;
    logic        w_wr_en_next;
    logic        w_rd_en_next;
    logic [13:0] w_addr_next;
    logic [15:0] w_wdata_next;
    logic [15:0] w_rsp_data_next;
    logic        w_rsp_err_next;

    assign cmd_ready      = (r_state == IDLE);
    assign rsp_valid      = (r_state == RESP);
    assign w_poll_cnt_inc = r_poll_cnt + 16'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_op       <= 2'b00;
            r_mask     <= '0;
            r_poll_cnt <= '0;
            r_gap_cnt  <= '0;
            wr_en      <= 1'b0;
            rd_en      <= 1'b0;
            addr       <= '0;
            write_data <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_op       <= w_op_next;
            r_mask     <= w_mask_next;
            r_poll_cnt <= w_poll_cnt_next;
            r_gap_cnt  <= w_gap_cnt_next;
            wr_en      <= w_wr_en_next;
            rd_en      <= w_rd_en_next;
            addr       <= w_addr_next;
            write_data <= w_wdata_next;
            rsp_data   <= w_rsp_data_next;
            rsp_err    <= w_rsp_err_next;
        end
    end

    // Strobes are computed one state early so they appear registered in ISSUE.
    always_comb begin
        w_state_next    = r_state;
        w_op_next       = r_op;
        w_mask_next     = r_mask;
        w_poll_cnt_next = r_poll_cnt;
        w_gap_cnt_next  = r_gap_cnt;
        w_wr_en_next    = 1'b0;
        w_rd_en_next    = 1'b0;
        w_addr_next     = addr;
        w_wdata_next    = write_data;
        w_rsp_data_next = rsp_data;
        w_rsp_err_next  = rsp_err;

        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_op_next       = cmd_op;
                    w_mask_next     = cmd_wdata;
                    w_poll_cnt_next = '0;
                    w_addr_next     = cmd_addr;
                    w_wdata_next    = (cmd_op == c_OP_WRITE) ? cmd_wdata : 16'h0000;
                    if (cmd_op == c_OP_RSVD) begin
                        w_state_next    = RESP;
                        w_rsp_data_next = '0;
                        w_rsp_err_next  = 1'b1;
                    end else begin
                        w_state_next = ISSUE;
                        w_wr_en_next = (cmd_op == c_OP_WRITE);
                        w_rd_en_next = (cmd_op != c_OP_WRITE);
                    end
                end
            end

            ISSUE: begin
                w_rsp_err_next = 1'b0;
                if (r_op == c_OP_WRITE) begin
                    w_state_next    = RESP;
                    w_rsp_data_next = '0;
                end else begin
                    w_poll_cnt_next = w_poll_cnt_inc;
                    w_rsp_data_next = read_data;
                    if ((r_op == c_OP_READ) || ((read_data & r_mask) != 16'h0000)) begin
                        w_state_next = RESP;
                    end else if (w_poll_cnt_inc == c_POLL_MAX) begin
                        w_state_next   = RESP;
                        w_rsp_err_next = 1'b1;
                    end else begin
                        w_state_next   = POLL_WAIT;
                        w_gap_cnt_next = '0;
                    end
                end
            end

            POLL_WAIT: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_state_next = ISSUE;
                    w_rd_en_next = 1'b1;
                end else begin
                    w_gap_cnt_next = r_gap_cnt + 16'd1;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_intf_master.sv
`default_nettype none
// Bench for reg_intf_master: directed and random commands against a
// transaction-level model of strobe timing and responses.
module tb_reg_intf_master;

    localparam int GAP  = 4;
    localparam int PMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [13:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        wr_en;
    logic        rd_en;
    logic [13:0] addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;

    reg_intf_master #(
        .POLL_GAP (GAP),
        .POLL_MAX (PMAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    // Register-file model: the n-th read of the current command returns rd_vals[n].
    logic [15:0] rd_vals [0:15];
    logic [3:0]  rd_idx;
    assign read_data = rd_vals[rd_idx];

    always @(posedge clk or negedge rst) begin
        if (!rst)                         rd_idx <= 4'd0;
        else if (cmd_valid && cmd_ready)  rd_idx <= 4'd0;
        else if (rd_en)                   rd_idx <= rd_idx + 4'd1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_wr_en"},      32'(wr_en),      32'd0);
        check({tag, "_rd_en"},      32'(rd_en),      32'd0);
        check({tag, "_addr"},       32'(addr),       32'd0);
        check({tag, "_write_data"}, 32'(write_data), 32'd0);
        check({tag, "_rsp_valid"},  32'(rsp_valid),  32'd0);
        check({tag, "_rsp_data"},   32'(rsp_data),   32'd0);
        check({tag, "_rsp_err"},    32'(rsp_err),    32'd0);
        check({tag, "_cmd_ready"},  32'(cmd_ready),  32'd1);
    endtask

    // Entered and left at a falling edge with the DUT idle.
    task automatic run_cmd(input logic [1:0] op, input logic [13:0] a,
                           input logic [15:0] wd, input int hold);
        int          n_reads;
        int          last_strobe;
        int          exp_rsp;
        bit          hit;
        bit          exp_wr;
        bit          exp_rd;
        logic [15:0] exp_data;
        logic        exp_err;

        n_reads  = 0;
        hit      = 1'b0;
        exp_data = 16'h0000;
        exp_err  = 1'b0;
        case (op)
            2'd1: begin
                n_reads  = 1;
                exp_data = rd_vals[0];
            end
            2'd2: begin
                for (int i = 0; i < PMAX && !hit; i++) begin
                    n_reads = i + 1;
                    if ((rd_vals[i] & wd) != 16'h0000) hit = 1'b1;
                end
                exp_data = rd_vals[n_reads-1];
                exp_err  = !hit;
            end
            2'd3: exp_err = 1'b1;
            default: ;
        endcase
        if (op == 2'd0)      last_strobe = 1;
        else if (op == 2'd3) last_strobe = 0;
        else                 last_strobe = 1 + (n_reads - 1) * (GAP + 1);
        exp_rsp = last_strobe + 1;

        check("idle_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = wd;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_addr  = 14'($urandom);
        cmd_wdata = 16'($urandom);

        for (int c = 1; c < exp_rsp; c++) begin
            exp_wr = (op == 2'd0) && (c == 1);
            exp_rd = ((op == 2'd1) || (op == 2'd2)) && (c <= last_strobe) && (((c - 1) % (GAP + 1)) == 0);
            check("wr_en",      32'(wr_en),     32'(exp_wr));
            check("rd_en",      32'(rd_en),     32'(exp_rd));
            check("busy_ready", 32'(cmd_ready), 32'd0);
            check("early_rsp",  32'(rsp_valid), 32'd0);
            if (exp_wr || exp_rd) begin
                check("addr",       32'(addr),       32'(a));
                check("write_data", 32'(write_data), exp_wr ? 32'(wd) : 32'd0);
            end
            @(negedge clk);
        end

        for (int h = 0; h <= hold; h++) begin
            check("rsp_valid",  32'(rsp_valid),     32'd1);
            check("rsp_data",   32'(rsp_data),      32'(exp_data));
            check("rsp_err",    32'(rsp_err),       32'(exp_err));
            check("resp_ready", 32'(cmd_ready),     32'd0);
            check("resp_strb",  32'(wr_en | rd_en), 32'd0);
            if (op != 2'd3) check("addr_hold", 32'(addr), 32'(a));
            if (h < hold) @(negedge clk);
        end

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_ready", 32'(cmd_ready), 32'd1);
        check("post_valid", 32'(rsp_valid), 32'd0);
    endtask

    logic [1:0]  r_op;
    logic [13:0] r_addr;
    logic [15:0] r_wd;
    logic [15:0] v;
    int          sel;
    int          hit_at;
    bit          seen;

    initial begin
        for (int i = 0; i < 16; i++) rd_vals[i] = 16'h0000;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b1;

        run_cmd(2'd0, 14'h0002, 16'hBEEF, 0);
        rd_vals[0] = 16'h0003;
        run_cmd(2'd1, 14'h0014, 16'h0000, 0);
        rd_vals[0] = 16'h0000; rd_vals[1] = 16'h0002; rd_vals[2] = 16'h0003; rd_vals[3] = 16'h0001;
        run_cmd(2'd2, 14'h0014, 16'h0001, 5);
        rd_vals[0] = 16'h1234; rd_vals[1] = 16'h0F0F; rd_vals[2] = 16'h7FFF; rd_vals[3] = 16'h2468;
        run_cmd(2'd2, 14'h0100, 16'h8000, 2);
        for (int i = 0; i < 16; i++) rd_vals[i] = 16'hFFFF;
        run_cmd(2'd2, 14'h0200, 16'h0000, 1);
        run_cmd(2'd3, 14'h0033, 16'h5555, 1);
        rd_vals[0] = 16'hA5A5;
        run_cmd(2'd1, 14'h3FFF, 16'h0000, 0);

        // Reset while the poll is waiting between reads.
        for (int i = 0; i < 16; i++) rd_vals[i] = 16'h0000;
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_addr = 14'h0014; cmd_wdata = 16'h0001;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rst_pre_rd", 32'(rd_en), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_reset_state("midrst");
        @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        repeat (2 * (GAP + 1) + 2) begin
            @(negedge clk);
            if (wr_en || rd_en) seen = 1'b1;
        end
        check("no_strobe_after_rst", 32'(seen), 32'd0);
        rd_vals[1] = 16'h0001;
        run_cmd(2'd2, 14'h0014, 16'h0001, 0);

        for (int k = 0; k < 40; k++) begin
            sel    = int'($urandom_range(0, 9));
            r_op   = (sel < 3) ? 2'd0 : (sel < 6) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
            r_addr = 14'($urandom);
            r_wd   = 16'($urandom);
            if (r_op == 2'd2 && $urandom_range(0, 4) == 0) r_wd = 16'h0000;
            hit_at = int'($urandom_range(0, PMAX + 1));
            for (int i = 0; i < 16; i++) begin
                v = 16'($urandom);
                if (r_op == 2'd2 && i < hit_at)  v = v & ~r_wd;
                if (r_op == 2'd2 && i == hit_at) v = (v & ~r_wd) | (r_wd & (~r_wd + 16'd1));
                rd_vals[i] = v;
            end
            run_cmd(r_op, r_addr, r_wd, int'($urandom_range(0, 5)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
